spi_nor_responder: RTL and testbench



---
 rtl/spi_nor_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/spi_nor_responder.sv | 210 +++++++++++++++++++++
 tb/tb_spi_nor_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_nor_pkg.sv
// Shared opcodes, frame states and status-register bit positions for the SPI NOR responder.
package spi_nor_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_SE    = 8'h20;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_FREAD = 8'h0B;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RD, PG, RDSR, IGNORE
  } frame_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for the asynchronous SPI pins plus edge strobes for s_clk and s_css.
module spi_pin_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_css,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_css_fall,
  output logic o_css_rise,
  output logic o_mosi
);

  logic [1:0] r_sclk_sync, r_css_sync, r_mosi_sync;
  logic       r_sclk_d, r_css_d;

  // Reset values match an idle bus so no false edge fires after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= 2'b00;
      r_css_sync  <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_css_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_css_sync  <= {r_css_sync[0], i_css};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_sclk_d    <= r_sclk_sync[1];
      r_css_d     <= r_css_sync[1];
    end
  end

  assign o_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
  assign o_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
  assign o_css_fall  = ~r_css_sync[1] & r_css_d;
  assign o_css_rise  = r_css_sync[1] & ~r_css_d;
  assign o_mosi      = r_mosi_sync[1];

endmodule

// File: rtl/spi_nor_responder.sv
// SPI mode-0 NOR flash responder: READ, PP, SE, RDSR, WREN, WRDI over an oversampled bus.
// Define SPI_NOR_FAST_READ_EN to accept FAST READ (0x0B) with one dummy byte.
module spi_nor_responder
  import spi_nor_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int PAGE_SIZE   = 256,
  parameter int SECTOR_SIZE = 1024,
  parameter int PROG_BUSY   = 64
) (
  input  logic p_clk,
  input  logic rst,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic s_miso_oe,
  output logic busy
);

  localparam int PG_W  = $clog2(PAGE_SIZE);
  localparam int SEC_W = $clog2(SECTOR_SIZE);
  localparam int CNT_W = $clog2(PROG_BUSY + 1);
`ifdef SPI_NOR_FAST_READ_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic w_rise, w_fall, w_css_fall, w_css_rise, w_mosi;

  spi_pin_sync u_sync (
    .i_clk      (p_clk),
    .i_rst      (rst),
    .i_sclk     (s_clk),
    .i_css      (s_css),
    .i_mosi     (s_mosi),
    .o_sclk_rise(w_rise),
    .o_sclk_fall(w_fall),
    .o_css_fall (w_css_fall),
    .o_css_rise (w_css_rise),
    .o_mosi     (w_mosi)
  );

  frame_state_e      r_state;
  logic [6:0]        r_sh;
  logic [2:0]        r_bcnt, r_txcnt;
  logic [1:0]        r_abyte;
  logic [7:0]        r_op, r_tx;
  logic [ADDR_W-1:0] r_addr, r_er_ptr, r_er_last;
  logic [CNT_W-1:0]  r_pg_cnt;
  logic              r_wel, r_pg_any, r_se_ok, r_er_active, r_miso, r_oe;
  logic [7:0]        mem [2**ADDR_W];

  logic [7:0]        w_byte, w_status;
  logic [ADDR_W-1:0] w_addr_nx;
  logic              w_wip, w_pg_we;

  assign w_byte    = {r_sh, w_mosi};
  assign w_addr_nx = {r_addr[ADDR_W-2:0], w_mosi};
  assign w_wip     = r_er_active || (r_pg_cnt != '0);
  assign w_pg_we   = !rst && !w_css_fall && !w_css_rise && w_rise &&
                     (r_state == PG) && (r_bcnt == 3'd7);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_status         = '0;
    w_status[ST_WIP] = w_wip;
    w_status[ST_WEL] = r_wel;
  end

  // NOTE: the array has no reset; the post-reset erase sweep initialises it instead.
  always_ff @(posedge p_clk) begin
    if (r_er_active)  mem[r_er_ptr] <= 8'hFF;
    else if (w_pg_we) mem[r_addr]   <= mem[r_addr] & w_byte;
  end

  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_bcnt      <= '0;
      r_txcnt     <= '0;
      r_abyte     <= '0;
      r_op        <= '0;
      r_tx        <= '0;
      r_addr      <= '0;
      r_wel       <= 1'b0;
      r_pg_any    <= 1'b0;
      r_se_ok     <= 1'b0;
      r_pg_cnt    <= '0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_er_active <= 1'b1;
      r_er_ptr    <= '0;
      r_er_last   <= '1;
    end else begin
      // WEL is held through a program/erase and drops when that operation completes.
      if (r_er_active) begin
        if (r_er_ptr == r_er_last) begin
          r_er_active <= 1'b0;
          r_wel       <= 1'b0;
        end else begin
          r_er_ptr <= r_er_ptr + ADDR_W'(1);
        end
      end
      if (r_pg_cnt != '0) begin
        r_pg_cnt <= r_pg_cnt - CNT_W'(1);
        if (r_pg_cnt == CNT_W'(1)) r_wel <= 1'b0;
      end

      if (w_css_fall) begin
        r_state  <= CMD;
        r_bcnt   <= '0;
        r_abyte  <= '0;
        r_pg_any <= 1'b0;
        r_se_ok  <= 1'b0;
        r_miso   <= 1'b0;
        r_oe     <= 1'b0;
      end else if (w_css_rise) begin
        r_state <= IDLE;
        r_miso  <= 1'b0;
        r_oe    <= 1'b0;
        r_se_ok <= 1'b0;
        if (r_state == PG && r_pg_any) r_pg_cnt <= CNT_W'(PROG_BUSY);
        if (r_state == IGNORE && r_se_ok) begin
          r_er_active <= 1'b1;
          r_er_ptr    <= {r_addr[ADDR_W-1:SEC_W], {SEC_W{1'b0}}};
          r_er_last   <= {r_addr[ADDR_W-1:SEC_W], {SEC_W{1'b1}}};
        end
      end else if (w_rise && r_state != IDLE) begin
        r_sh   <= w_byte[6:0];
        r_bcnt <= r_bcnt + 3'd1;
        case (r_state)
          CMD: if (r_bcnt == 3'd7) begin
            r_op <= w_byte;
            if (w_wip && w_byte != OP_RDSR) begin
              r_state <= IGNORE;
            end else begin
              case (w_byte)
                OP_WREN:                begin r_wel <= 1'b1; r_state <= IGNORE; end
                OP_WRDI:                begin r_wel <= 1'b0; r_state <= IGNORE; end
                OP_RDSR:                begin r_state <= RDSR; r_oe <= 1'b1; r_txcnt <= '0; end
                OP_READ, OP_PP, OP_SE:  r_state <= ADDR;
                OP_FREAD:               r_state <= FAST_EN ? ADDR : IGNORE;
                default:                r_state <= IGNORE;
              endcase
            end
          end
          ADDR: begin
            r_addr <= w_addr_nx;
            if (r_bcnt == 3'd7) begin
              r_abyte <= r_abyte + 2'd1;
              if (r_abyte == 2'd2) begin
                case (r_op)
                  OP_READ: begin
                    r_state <= RD;
                    r_oe    <= 1'b1;
                    r_tx    <= mem[w_addr_nx];
                    r_addr  <= w_addr_nx + ADDR_W'(1);
                    r_txcnt <= '0;
                  end
                  OP_PP:   r_state <= r_wel ? PG : IGNORE;
                  OP_SE:   begin r_state <= IGNORE; r_se_ok <= r_wel; end
                  default: r_state <= DUMMY;
                endcase
              end
            end
          end
          DUMMY: if (r_bcnt == 3'd7) begin
            r_state <= RD;
            r_oe    <= 1'b1;
            r_tx    <= mem[r_addr];
            r_addr  <= r_addr + ADDR_W'(1);
            r_txcnt <= '0;
          end
          PG: if (r_bcnt == 3'd7) begin
            r_addr   <= {r_addr[ADDR_W-1:PG_W], r_addr[PG_W-1:0] + PG_W'(1)};
            r_pg_any <= 1'b1;
          end
          IGNORE:  r_se_ok <= 1'b0;
          default: ;
        endcase
      end else if (w_fall) begin
        case (r_state)
          RD: begin
            r_miso  <= r_tx[7];
            r_txcnt <= r_txcnt + 3'd1;
            if (r_txcnt == 3'd7) begin
              r_tx   <= mem[r_addr];
              r_addr <= r_addr + ADDR_W'(1);
            end else begin
              r_tx <= {r_tx[6:0], 1'b0};
            end
          end
          RDSR: begin
            r_miso  <= w_status[3'd7 - r_txcnt];
            r_txcnt <= r_txcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign s_miso    = r_miso;
  assign s_miso_oe = r_oe;
  assign busy      = w_wip;

endmodule

// File: tb/tb_spi_nor_responder.sv
// Randomised bench for spi_nor_responder driven as an SPI mode-0 master against a byte-array model.
module tb_spi_nor_responder;

  logic p_clk = 1'b0, rst = 1'b1, s_clk = 1'b0, s_css = 1'b1, s_mosi = 1'b0;
  logic s_miso, s_miso_oe, busy;

  int checks = 0, failures = 0;
  int h = 8;          // s_clk half period in p_clk cycles
  bit fix_h = 1'b0;
  int oe_hi;          // master samples that saw s_miso_oe high in the current frame
  logic [7:0] model_mem [4096];
  bit model_wel;
  logic [7:0] rx_q[$];

  spi_nor_responder dut (
    .p_clk    (p_clk),
    .rst      (rst),
    .s_clk    (s_clk),
    .s_css    (s_css),
    .s_mosi   (s_mosi),
    .s_miso   (s_miso),
    .s_miso_oe(s_miso_oe),
    .busy     (busy)
  );

  always #5 p_clk = ~p_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    s_mosi = mo;
    wait_clk(h);
    mi = s_miso;
    if (s_miso_oe) oe_hi++;
    s_clk = 1'b1;
    wait_clk(h);
    s_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic m;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], m);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, m);
      b[i] = m;
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic frame_start();
    if (!fix_h) h = $urandom_range(6, 8);
    oe_hi = 0;
    s_css = 1'b0;
    wait_clk(h);
  endtask

  task automatic frame_end();
    wait_clk(h);
    s_css = 1'b1;
  endtask

  task automatic gap();
    wait_clk(3 * h);
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    frame_start();
    send_byte(op);
    frame_end();
    gap();
  endtask

  task automatic rdsr(output logic [7:0] s);
    frame_start();
    send_byte(8'h05);
    recv_byte(s);
    frame_end();
    gap();
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    frame_start();
    send_byte(8'h03);
    send_addr(a);
    rx_q.delete();
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      rx_q.push_back(b);
    end
    frame_end();
    gap();
  endtask

  // Read n bytes and compare with the model; the address wraps over the implemented 12 bits.
  task automatic check_read(input string tag, input logic [23:0] a, input int n);
    logic [11:0] idx;
    spi_read(a, n);
    for (int i = 0; i < n; i++) begin
      idx = a[11:0] + 12'(i);
      check($sformatf("%s[%0d]", tag, i), rx_q[i], model_mem[idx]);
    end
    check({tag, "_oe"}, oe_hi, 8 * n);
  endtask

  task automatic spi_pp(input logic [23:0] a, input logic [7:0] d[$]);
    frame_start();
    send_byte(8'h02);
    send_addr(a);
    foreach (d[i]) send_byte(d[i]);
    frame_end();
  endtask

  // Wait (bounded) for busy to rise, then count cycles it stays high; 0 if it never rose.
  task automatic measure_busy(output int n);
    int w;
    w = 0;
    n = 0;
    while (!busy && w < 100) begin wait_clk(1); w++; end
    while (busy && n < 6000) begin n++; wait_clk(1); end
  endtask

  task automatic model_pp(input logic [23:0] a, input logic [7:0] d[$]);
    logic [11:0] idx;
    foreach (d[i]) begin
      idx = {a[11:8], a[7:0] + 8'(i)};
      model_mem[idx] = model_mem[idx] & d[i];
    end
  endtask

  task automatic pp_exec(input string tag, input logic [23:0] a, input logic [7:0] d[$]);
    int n;
    simple_cmd(8'h06);
    spi_pp(a, d);
    measure_busy(n);
    check({tag, "_busy"}, n, 64);
    model_pp(a, d);
    model_wel = 1'b0;
    gap();
  endtask

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(0, 254));
  endfunction

  initial begin
    int n, len;
    logic [7:0] st, m8;
    logic [7:0] dq[$];
    logic [23:0] a;
    logic m;

    for (int i = 0; i < 4096; i++) model_mem[i] = 8'hFF;
    model_wel = 1'b0;

    wait_clk(4);
    check("rst_miso", s_miso, 0);
    check("rst_oe", s_miso_oe, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 6000) begin n++; wait_clk(1); end
    check("init_busy_cycles", n, 4096);
    wait_clk(10);
    rdsr(st);
    check("rdsr_init", st, 8'h00);
    check_read("rd_init", 24'h000010, 4);

    dq = {8'h12, 8'h34};
    pp_exec("pp100", 24'h000100, dq);
    rdsr(st);
    check("rdsr_after_pp", st, 8'h00);
    check_read("rd_pp100", 24'h000100, 3);

    dq = {8'h00};
    spi_pp(24'h000200, dq);
    wait_clk(40);
    check("pp_nowel_busy", busy, 0);
    gap();
    rdsr(st);
    check("rdsr_nowel", st, 8'h00);
    check_read("rd_nowel", 24'h000200, 1);

    dq = {8'hAA, 8'h55};
    pp_exec("pp1ff", 24'h0001FF, dq);
    check_read("rd_wrap_1ff", 24'h0001FF, 1);
    check_read("rd_wrap_100", 24'h000100, 1);
    check_read("rd_wrap_200", 24'h000200, 1);

    // Mark both sector boundaries and the interior so the erase is visible.
    dq = {rnd_byte()};             pp_exec("pp3ff", 24'h0003FF, dq);
    dq = {rnd_byte(), rnd_byte()}; pp_exec("pp7fe", 24'h0007FE, dq);
    dq = {rnd_byte()};             pp_exec("pp800", 24'h000800, dq);
    dq = {rnd_byte()};             pp_exec("pp523", 24'h000523, dq);

    simple_cmd(8'h06);
    fix_h = 1'b1;
    h = 6;
    frame_start();
    send_byte(8'h20);
    send_addr(24'h000523);
    frame_end();
    fork
      measure_busy(n);
      begin
        int w;
        w = 0;
        while (!busy && w < 100) begin wait_clk(1); w++; end
        rdsr(st);
        check("rdsr_during_se", st, 8'h03);
        spi_read(24'h000410, 1);
        check("read_during_se_oe", oe_hi, 0);
      end
    join
    fix_h = 1'b0;
    check("se_busy_cycles", n, 1024);
    for (int i = 12'h400; i <= 12'h7FF; i++) model_mem[i] = 8'hFF;
    model_wel = 1'b0;
    rdsr(st);
    check("rdsr_after_se", st, 8'h00);
    check_read("rd_se_lo", 24'h0003FF, 2);
    check_read("rd_se_hi", 24'h0007FE, 3);
    check_read("rd_se_mid", {12'h000, 12'(12'h400 + $urandom_range(0, 1023))}, 1);

    // Erase frame with one bit too many must be dropped and keep WEL.
    dq = {8'h5A};
    pp_exec("pp523b", 24'h000523, dq);
    simple_cmd(8'h06);
    frame_start();
    send_byte(8'h20);
    send_addr(24'h000523);
    spi_bit(1'b0, m);
    frame_end();
    wait_clk(40);
    check("se33_no_busy", busy, 0);
    gap();
    rdsr(st);
    check("rdsr_se33_wel", st, 8'h02);
    check_read("rd_se33", 24'h000523, 1);
    simple_cmd(8'h04);
    rdsr(st);
    check("rdsr_wrdi", st, 8'h00);

    // Partial data byte is discarded and WEL survives.
    simple_cmd(8'h06);
    frame_start();
    send_byte(8'h02);
    send_addr(24'h000300);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
    frame_end();
    wait_clk(40);
    check("partial_no_busy", busy, 0);
    gap();
    rdsr(st);
    check("rdsr_partial_wel", st, 8'h02);
    check_read("rd_partial", 24'h000300, 1);

    dq = {rnd_byte()}; pp_exec("ppfff", 24'hABCFFF, dq);
    dq = {rnd_byte()}; pp_exec("pp000", 24'h000000, dq);
    check_read("rd_wrap_fff", 24'h000FFF, 2);

    frame_start();
    send_byte(8'h0B);
    send_addr(24'h000100);
    send_byte(8'h00);
    recv_byte(m8);
    frame_end();
    gap();
`ifdef SPI_NOR_FAST_READ_EN
    check("fread_data", m8, model_mem[12'h100]);
    check("fread_oe", oe_hi, 8);
`else
    check("fread_ignored_oe", oe_hi, 0);
`endif

    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      len = $urandom_range(1, 4);
      dq.delete();
      for (int i = 0; i < len; i++) dq.push_back(8'($urandom));
      pp_exec($sformatf("rnd_pp%0d", it), a, dq);
      check_read($sformatf("rnd_rd%0d", it), a - 24'd1, $urandom_range(1, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
